// File: rtl/im_fetch_ctrl_pkg.sv
// Shared constants for the instruction-fetch sequencer: next-PC selects,
// FSM state encodings and the default boot address.
package im_fetch_ctrl_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

endpackage

// File: rtl/im_fetch_ctrl_if.sv
// Read port of the synchronous instruction memory: request and word index
// go out, data returns one cycle after the request.
interface im_fetch_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              im_req;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_rdata;

  modport master (output im_req, output im_addr, input im_rdata);
  modport slave  (input im_req, input im_addr, output im_rdata);
endinterface

// File: rtl/im_fetch_ctrl_npc_calc.sv
// Combinational next-PC selection for the instruction currently in decode,
// plus a flag telling whether that target lies inside the instruction memory.
module im_fetch_ctrl_npc_calc
  import im_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          ADDR_W   = 10
) (
  input  logic [31:0] pc,
  input  logic [1:0]  npc_sel,
  input  logic        branch_taken,
  input  logic [15:0] im16,
  input  logic [25:0] im26,
  input  logic [31:0] ra_val,
  output logic [31:0] next_pc,
  output logic        legal
);

  localparam logic [32:0] SPAN = 33'd4 << ADDR_W;

  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [32:0] tgt_ext;

  assign pc4    = pc + 32'd4;
  assign br_off = {{14{im16[15]}}, im16, 2'b00};

  always_comb begin
    // NOTE: default assignment first so every path drives next_pc and no latch is inferred.
    next_pc = pc4;
    case (npc_sel)
      NPC_BR:  next_pc = branch_taken ? pc4 + br_off : pc4;
      NPC_J:   next_pc = {pc4[31:28], im26, 2'b00};
      NPC_JR:  next_pc = ra_val;
      default: next_pc = pc4;
    endcase
  end

  // Widened compare so the upper bound cannot wrap.
  assign tgt_ext = {1'b0, next_pc};
  assign legal   = (next_pc[1:0] == 2'b00) &&
                   (tgt_ext >= {1'b0, RESET_PC}) &&
                   (tgt_ext <  {1'b0, RESET_PC} + SPAN);

endmodule

// File: rtl/im_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues 1-cycle-latency reads, holds the
// fetched word across stalls and halts permanently on an illegal target.
module im_fetch_ctrl
  import im_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          ADDR_W   = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [1:0]            npc_sel,
  input  logic                  branch_taken,
  input  logic [15:0]           im16,
  input  logic [25:0]           im26,
  input  logic [31:0]           ra_val,
  im_fetch_ctrl_if.master       mem,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  output logic [31:0]           pc,
  output logic [31:0]           pc8,
  output logic                  halted,
  output logic [31:0]           retired_cnt
);

  logic [1:0]  state;
  logic [31:0] hold_reg;
  logic [31:0] next_pc;
  logic [31:0] tgt;
  logic [31:0] tgt_off;
  logic        legal;
  logic        active;
  logic        advance;

  im_fetch_ctrl_npc_calc #(
    .RESET_PC (RESET_PC),
    .ADDR_W   (ADDR_W)
  ) u_npc_calc (
    .pc           (pc),
    .npc_sel      (npc_sel),
    .branch_taken (branch_taken),
    .im16         (im16),
    .im26         (im26),
    .ra_val       (ra_val),
    .next_pc      (next_pc),
    .legal        (legal)
  );

  assign active      = (state == ST_RUN) || (state == ST_STALL);
  assign advance     = active && !stall;
  assign instr_valid = active;
  assign pc8         = pc + 32'd8;

  always_comb begin
    instr = '0;
    if (state == ST_RUN)        instr = mem.im_rdata;
    else if (state == ST_STALL) instr = hold_reg;
  end

  always_comb begin
    tgt = next_pc;
    if (state == ST_BOOT) tgt = RESET_PC;
  end

  assign tgt_off     = tgt - RESET_PC;
  assign mem.im_addr = ADDR_W'(tgt_off >> 2);
  // Gated with reset so the read port is quiet while reset is held.
  assign mem.im_req  = reset && ((state == ST_BOOT) || (advance && legal));

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_BOOT;
      pc          <= RESET_PC;
      hold_reg    <= '0;
      retired_cnt <= '0;
      halted      <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN, ST_STALL: begin
          if (stall) begin
            // Memory output is only valid for one cycle; capture it on stall entry.
            if (state == ST_RUN) hold_reg <= mem.im_rdata;
            state <= ST_STALL;
          end else begin
            retired_cnt <= retired_cnt + 32'd1;
            if (legal) begin
              pc    <= next_pc;
              state <= ST_RUN;
            end else begin
              halted <= 1'b1;
              state  <= ST_HALT;
            end
          end
        end
        default: state <= ST_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Scoreboard bench for im_fetch_ctrl: a 1-cycle memory model feeds the DUT and
// a reference model predicts each cycle's outputs into a queue.
module tb_im_fetch_ctrl;

  localparam logic [31:0] RPC = 32'h0000_3000;
  localparam int M_BOOT = 0, M_RUN = 1, M_STALL = 2, M_HALT = 3;

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] ret;
    logic        halted;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  npc_sel = 2'b00;
  logic        branch_taken = 1'b0;
  logic [15:0] im16 = '0;
  logic [25:0] im26 = '0;
  logic [31:0] ra_val = '0;
  logic [31:0] instr, pc, pc8, retired_cnt;
  logic        instr_valid, halted;

  logic [31:0] mem [1024];
  exp_t        sbq [$];
  int          n_tests = 0;
  int          n_fail = 0;

  int          m_st;
  logic [31:0] m_pc, m_hold, m_ret;
  logic        m_halt;

  im_fetch_ctrl_if #(.ADDR_W(10)) bus ();

  im_fetch_ctrl #(.RESET_PC(RPC), .ADDR_W(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .npc_sel      (npc_sel),
    .branch_taken (branch_taken),
    .im16         (im16),
    .im26         (im26),
    .ra_val       (ra_val),
    .mem          (bus),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .pc8          (pc8),
    .halted       (halted),
    .retired_cnt  (retired_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory; a poison word when not requested exposes a missing hold.
  always @(posedge clk) bus.im_rdata <= bus.im_req ? mem[bus.im_addr] : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] o;
    o = (a - RPC) >> 2;
    return mem[o[9:0]];
  endfunction

  function automatic logic [31:0] m_npc(input logic [31:0] p, input logic [1:0] sel,
                                        input logic tk, input logic [15:0] i16,
                                        input logic [25:0] i26, input logic [31:0] ra);
    logic [31:0] p4;
    p4 = p + 32'd4;
    case (sel)
      2'b01:   return tk ? p4 + (32'($signed(i16)) << 2) : p4;
      2'b10:   return {p4[31:28], i26, 2'b00};
      2'b11:   return ra;
      default: return p4;
    endcase
  endfunction

  function automatic logic m_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= RPC) && (a < RPC + 32'd4096);
  endfunction

  task automatic compare_pop();
    exp_t e;
    if (sbq.size() == 0) return;
    e = sbq.pop_front();
    check("instr_valid", instr_valid, e.valid);
    check("instr", instr, e.instr);
    check("pc", pc, e.pc);
    check("pc8", pc8, e.pc + 32'd8);
    check("retired_cnt", retired_cnt, e.ret);
    check("halted", halted, e.halted);
  endtask

  // One cycle: compare last prediction, drive inputs, check the read port, predict next.
  task automatic step(input logic st, input logic [1:0] sel, input logic tk,
                      input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] ra);
    logic [31:0] nxt, cur;
    logic        lg, act, exp_req;
    exp_t        e;
    compare_pop();
    stall = st; npc_sel = sel; branch_taken = tk; im16 = i16; im26 = i26; ra_val = ra;
    #1;
    cur     = (m_st == M_RUN) ? word_at(m_pc) : m_hold;
    nxt     = m_npc(m_pc, sel, tk, i16, i26, ra);
    lg      = m_legal(nxt);
    act     = (m_st == M_RUN) || (m_st == M_STALL);
    exp_req = (m_st == M_BOOT) || (act && !st && lg);
    check("im_req", bus.im_req, exp_req);
    if (exp_req) check("im_addr", bus.im_addr, (m_st == M_BOOT) ? 32'd0 : (nxt - RPC) >> 2);
    case (m_st)
      M_BOOT: m_st = M_RUN;
      M_RUN, M_STALL: begin
        if (st) begin
          if (m_st == M_RUN) m_hold = cur;
          m_st = M_STALL;
        end else begin
          m_ret = m_ret + 32'd1;
          if (lg) begin
            m_pc = nxt;
            m_st = M_RUN;
          end else begin
            m_halt = 1'b1;
            m_st = M_HALT;
          end
        end
      end
      default: ;
    endcase
    e.valid  = (m_st == M_RUN) || (m_st == M_STALL);
    e.instr  = (m_st == M_RUN) ? word_at(m_pc) : (m_st == M_STALL) ? m_hold : 32'd0;
    e.pc     = m_pc;
    e.ret    = m_ret;
    e.halted = m_halt;
    sbq.push_back(e);
    @(negedge clk);
  endtask

  // Asserts reset wherever it is called; releases on the following negedge.
  task automatic do_reset();
    reset = 1'b0;
    sbq.delete();
    m_st = M_BOOT; m_pc = RPC; m_hold = '0; m_ret = '0; m_halt = 1'b0;
    #1;
    check("rst_im_req", bus.im_req, 1'b0);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", pc, RPC);
    check("rst_retired", retired_cnt, 32'd0);
    check("rst_halted", halted, 1'b0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    #2;
    do_reset();
    // Straight-line fetch, branches both ways, j and jr.
    step(0, 2'b00, 0, 16'h0,    26'h0,       32'h0);        // BOOT
    step(0, 2'b00, 0, 16'h0,    26'h0,       32'h0);        // 3000 -> 3004
    step(0, 2'b00, 0, 16'h0,    26'h0,       32'h0);        // 3004 -> 3008
    step(0, 2'b01, 1, 16'hFFFE, 26'h0,       32'h0);        // beq taken -> 3004
    step(0, 2'b00, 0, 16'h0,    26'h0,       32'h0);        // -> 3008
    step(0, 2'b01, 0, 16'hFFFE, 26'h0,       32'h0);        // not taken -> 300C
    step(0, 2'b00, 0, 16'h0,    26'h0,       32'h0);        // -> 3010
    step(0, 2'b10, 0, 16'h0,    26'h0000C10, 32'h0);        // j -> 3040
    step(0, 2'b11, 0, 16'h0,    26'h0,       32'h0000301C); // jr -> 301C
    step(0, 2'b11, 0, 16'h0,    26'h0,       32'h00003004); // jr -> 3004
    // Three-cycle stall at 3004, then advance on release.
    for (int i = 0; i < 3; i++) step(1, 2'b00, 0, 16'h0, 26'h0, 32'h0);
    step(0, 2'b00, 0, 16'h0,    26'h0,       32'h0);        // -> 3008
    step(0, 2'b00, 0, 16'h0,    26'h0,       32'h0);        // -> 300C
    step(0, 2'b11, 0, 16'h0,    26'h0,       32'h00003FFC); // last legal word
    step(0, 2'b00, 0, 16'h0,    26'h0,       32'h0);        // 4000 illegal -> HALT
    for (int i = 0; i < 3; i++) step(1'(i), 2'b00, 0, 16'h0, 26'h0, 32'h0);
    // Misaligned jr target.
    do_reset();
    step(0, 2'b00, 0, 16'h0,    26'h0,       32'h0);
    step(0, 2'b11, 0, 16'h0,    26'h0,       32'h00003002);
    for (int i = 0; i < 2; i++) step(0, 2'b00, 0, 16'h0, 26'h0, 32'h0);
    // Out-of-range jr target.
    do_reset();
    step(0, 2'b00, 0, 16'h0,    26'h0,       32'h0);
    step(0, 2'b11, 0, 16'h0,    26'h0,       32'h00004000);
    for (int i = 0; i < 2; i++) step(0, 2'b00, 0, 16'h0, 26'h0, 32'h0);
    // Reset asserted while in STALL.
    do_reset();
    step(0, 2'b00, 0, 16'h0,    26'h0,       32'h0);
    step(0, 2'b00, 0, 16'h0,    26'h0,       32'h0);
    step(1, 2'b00, 0, 16'h0,    26'h0,       32'h0);
    step(1, 2'b00, 0, 16'h0,    26'h0,       32'h0);
    #2;
    do_reset();
    step(1, 2'b00, 0, 16'h0,    26'h0,       32'h0);        // stall ignored in BOOT
    for (int i = 0; i < 4; i++) step(0, 2'b00, 0, 16'h0, 26'h0, 32'h0);
    compare_pop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
